// File: rtl/ysyx_23060184_axil_sram.sv
// ---------------------------------------------------------------------------
// ysyx_23060184_axil_sram
//
// AXI4-Lite SRAM slave backed by an internal word array. The read and write
// channels run as two independent FSMs with programmable wait cycles, so a
// read and a write can be in flight at the same time.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high. A slave valid, once raised, stays
// high with its payload frozen until that edge.
//
// Ports:
//   clk, rstn                      clock (rising edge), async active-low reset
//   araddr/arvalid/arready         read address channel
//   rdata/rresp/rvalid/rready      read data channel (rresp 00 OKAY, 11 DECERR)
//   awaddr/awvalid/awready         write address channel
//   wdata/wstrb/wvalid/wready      write data channel with byte strobes
//   bresp/bvalid/bready            write response channel (00 OKAY, 11 DECERR)
//
// Addresses outside [BASE_ADDR, BASE_ADDR + window) get DECERR; reads return
// zero and writes change nothing. Byte-offset address bits are ignored.
// Memory contents are not cleared by reset.
// ---------------------------------------------------------------------------
module ysyx_23060184_axil_sram #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH_LOG2 = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                    RD_LAT     = 1,
    parameter int                    WR_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int OFF_BITS = (DATA_WIDTH == 64) ? 3 : 2;
    localparam int WIN_BITS = DEPTH_LOG2 + OFF_BITS;
    localparam int DEPTH    = 1 << DEPTH_LOG2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wr_state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // BASE_ADDR is aligned to the window size, so the window test reduces
    // to comparing the address bits above the window.
    logic                  w_ar_hit;
    logic                  w_aw_hit;
    logic                  w_unused_addr_lsb;

    assign w_ar_hit = (araddr[ADDR_WIDTH-1:WIN_BITS] == BASE_ADDR[ADDR_WIDTH-1:WIN_BITS]);
    assign w_aw_hit = (awaddr[ADDR_WIDTH-1:WIN_BITS] == BASE_ADDR[ADDR_WIDTH-1:WIN_BITS]);
    assign w_unused_addr_lsb = ^{araddr[OFF_BITS-1:0], awaddr[OFF_BITS-1:0]};

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t             r_rd_state;
    rd_state_t             w_rd_next;
    logic [3:0]            r_rd_cnt;
    logic [DEPTH_LOG2-1:0] r_ar_idx;
    logic                  r_ar_ok;
    logic                  w_ar_hs;
    logic                  w_rd_fire;

    assign w_ar_hs   = arvalid && arready;
    assign w_rd_fire = (r_rd_state == R_WAIT) && (r_rd_cnt == 4'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Every read passes through R_WAIT, which holds the single array
    // sample point; with RD_LAT=0 it lasts exactly one cycle.
    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs)             w_rd_next = R_WAIT;
            R_WAIT:  if (r_rd_cnt == 4'd0)    w_rd_next = R_RESP;
            R_RESP:  if (rready)              w_rd_next = R_IDLE;
            default:                          w_rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_rd_state == R_IDLE);
        rvalid  = (r_rd_state == R_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_cnt <= 4'd0;
            r_ar_idx <= '0;
            r_ar_ok  <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            if (w_ar_hs) begin
                r_ar_idx <= araddr[WIN_BITS-1:OFF_BITS];
                r_ar_ok  <= w_ar_hit;
                r_rd_cnt <= 4'(RD_LAT);
            end else if ((r_rd_state == R_WAIT) && (r_rd_cnt != 4'd0)) begin
                r_rd_cnt <= r_rd_cnt - 4'd1;
            end
            // Sampled with a non-blocking read, so a commit on the same edge
            // is not yet visible here.
            if (w_rd_fire) begin
                rdata <= r_ar_ok ? r_mem[r_ar_idx] : '0;
                rresp <= r_ar_ok ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t             r_wr_state;
    wr_state_t             w_wr_next;
    logic [3:0]            r_wr_cnt;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic [DEPTH_LOG2-1:0] r_aw_idx;
    logic                  r_aw_ok;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_wr_both;
    logic                  w_wr_fire;

    assign w_aw_hs   = awvalid && awready;
    assign w_w_hs    = wvalid && wready;
    // Both halves present, counting ones captured on this very edge.
    assign w_wr_both = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_wr_fire = (r_wr_state == W_WAIT) && (r_wr_cnt == 4'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_next;
        end
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE:  if (w_wr_both)           w_wr_next = W_WAIT;
            W_WAIT:  if (r_wr_cnt == 4'd0)    w_wr_next = W_RESP;
            W_RESP:  if (bready)              w_wr_next = W_IDLE;
            default:                          w_wr_next = W_IDLE;
        endcase
    end

    // The held flags stay set through W_WAIT/W_RESP, so both readies stay
    // low until the B handshake clears them together.
    always_comb begin
        awready = (r_wr_state == W_IDLE) && !r_aw_held;
        wready  = (r_wr_state == W_IDLE) && !r_w_held;
        bvalid  = (r_wr_state == W_RESP);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_cnt  <= 4'd0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_aw_idx  <= '0;
            r_aw_ok   <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            bresp     <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_idx  <= awaddr[WIN_BITS-1:OFF_BITS];
                r_aw_ok   <= w_aw_hit;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= wdata;
                r_wstrb  <= wstrb;
            end
            if ((r_wr_state == W_RESP) && bready) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end
            if ((r_wr_state == W_IDLE) && w_wr_both) begin
                r_wr_cnt <= 4'(WR_LAT);
            end else if ((r_wr_state == W_WAIT) && (r_wr_cnt != 4'd0)) begin
                r_wr_cnt <= r_wr_cnt - 4'd1;
            end
            if (w_wr_fire) begin
                bresp <= r_aw_ok ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // Array write port. Commit is gated by the FSM state, which reset
    // forces to W_IDLE, so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (w_wr_fire && r_aw_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (r_wstrb[i]) begin
                    r_mem[r_aw_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_axil_sram.sv
module tb_ysyx_23060184_axil_sram;

    localparam int          RD_LAT = 1;
    localparam int          WR_LAT = 1;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam longint      WIN    = 4096 * 4;

    logic        clk;
    logic        rstn;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    ysyx_23060184_axil_sram #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(12),
        .BASE_ADDR(32'h8000_0000), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Transaction-level view: a read is outstanding from its AR handshake to
    // its R handshake and its response is due RD_LAT+1 edges after AR; a
    // write is due WR_LAT+1 edges after both halves are in.
    logic [31:0] mdl_mem [int];
    bit          m_rbusy, m_rvalid, m_rknown, m_aw, m_w, m_bvalid;
    int          m_rcnt, m_wcnt;
    logic [31:0] m_raddr, m_waddr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_rresp, m_bresp;

    function automatic bit in_rng(input logic [31:0] a);
        longint ua;
        ua = longint'({32'b0, a});
        return (ua >= longint'({32'b0, BASE})) && (ua < longint'({32'b0, BASE}) + WIN);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_rbusy = 0; m_rvalid = 0; m_rcnt = 0; m_rresp = 2'b00;
                m_aw = 0; m_w = 0; m_bvalid = 0; m_wcnt = 0; m_bresp = 2'b00;
            end else begin
                bit busy_pre;
                busy_pre = m_rbusy;
                // read side first: samples the array before this edge's commit
                if (m_rvalid && rready) begin
                    m_rvalid = 0; m_rbusy = 0;
                end else if (m_rcnt > 0) begin
                    m_rcnt--;
                    if (m_rcnt == 0) begin
                        m_rvalid = 1;
                        if (!in_rng(m_raddr)) begin
                            m_rdata = 0; m_rresp = 2'b11; m_rknown = 1;
                        end else begin
                            m_rresp  = 2'b00;
                            m_rknown = mdl_mem.exists(widx(m_raddr));
                            m_rdata  = m_rknown ? mdl_mem[widx(m_raddr)] : 32'h0;
                        end
                    end
                end
                if (!busy_pre && arvalid) begin
                    m_rbusy = 1; m_raddr = araddr; m_rcnt = RD_LAT + 1;
                end
                // write side
                if (m_bvalid && bready) begin
                    m_bvalid = 0; m_aw = 0; m_w = 0;
                end else if (m_wcnt > 0) begin
                    m_wcnt--;
                    if (m_wcnt == 0) begin
                        m_bvalid = 1;
                        if (in_rng(m_waddr)) begin
                            m_bresp = 2'b00;
                            if (mdl_mem.exists(widx(m_waddr))) begin
                                logic [31:0] v;
                                v = mdl_mem[widx(m_waddr)];
                                for (int b = 0; b < 4; b++)
                                    if (m_wstrb[b]) v[8*b +: 8] = m_wdata[8*b +: 8];
                                mdl_mem[widx(m_waddr)] = v;
                            end else if (m_wstrb == 4'hF) begin
                                mdl_mem[widx(m_waddr)] = m_wdata;
                            end
                        end else begin
                            m_bresp = 2'b11;
                        end
                    end
                end else if (!m_bvalid) begin
                    if (!m_aw && awvalid) begin m_aw = 1; m_waddr = awaddr; end
                    if (!m_w && wvalid) begin m_w = 1; m_wdata = wdata; m_wstrb = wstrb; end
                    if (m_aw && m_w) m_wcnt = WR_LAT + 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rstn) begin
                chk("cmp_arready", arready, !m_rbusy);
                chk("cmp_rvalid",  rvalid,  m_rvalid);
                chk("cmp_awready", awready, !m_aw);
                chk("cmp_wready",  wready,  !m_w);
                chk("cmp_bvalid",  bvalid,  m_bvalid);
                if (m_rvalid) begin
                    chk("cmp_rresp", rresp, m_rresp);
                    if (m_rknown) chk("cmp_rdata", rdata, m_rdata);
                end
                if (m_bvalid) chk("cmp_bresp", bresp, m_bresp);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // lat = negedge count after the AR edge at which rvalid is first seen
    task automatic rd(input logic [31:0] a, input int hold,
                      output logic [31:0] d, output logic [1:0] r, output int lat);
        int g;
        logic [31:0] d0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        g = 0;
        while (!arready && g < 100) begin @(negedge clk); g++; end
        chk("ar_accept", arready, 1'b1);
        @(negedge clk);
        arvalid = 1'b0;
        lat = 1;
        while (!rvalid && lat < 100) begin @(negedge clk); lat++; end
        chk("rvalid_seen", rvalid, 1'b1);
        d0 = rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_rvalid", rvalid, 1'b1);
            chk("bp_rdata", rdata, d0);
            chk("bp_arready", arready, 1'b0);
        end
        d = rdata; r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("arready_after_r", arready, 1'b1);
    endtask

    // lat = edges from the later AW/W handshake edge to bvalid
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int lead, input int hold, output logic [1:0] r, output int lat);
        int cyc, n;
        logic ah, wh, a_sent;
        logic [1:0] b0;
        @(negedge clk);
        wdata = d; wstrb = s; wvalid = 1'b1; bready = (hold == 0);
        a_sent = 1'b0;
        if (lead == 0) begin awaddr = a; awvalid = 1'b1; a_sent = 1'b1; end
        cyc = 0;
        while ((awvalid || wvalid || !a_sent) && cyc < 100) begin
            ah = awvalid && awready;
            wh = wvalid && wready;
            @(negedge clk);
            cyc++;
            if (ah) awvalid = 1'b0;
            if (wh) wvalid = 1'b0;
            if (!a_sent && cyc >= lead) begin
                chk("wready_low_w_first", wready, 1'b0);
                awaddr = a; awvalid = 1'b1; a_sent = 1'b1;
            end
        end
        chk("aw_w_accept", {awvalid, wvalid}, 2'b00);
        n = 1;
        while (!bvalid && n < 100) begin @(negedge clk); n++; end
        chk("bvalid_seen", bvalid, 1'b1);
        lat = n - 1;
        b0 = bresp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_bvalid", bvalid, 1'b1);
            chk("bp_bresp", bresp, b0);
            chk("bp_awready", awready, 1'b0);
            chk("bp_wready", wready, 1'b0);
        end
        r = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("awready_after_b", awready, 1'b1);
        chk("wready_after_b", wready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_arready"}, arready, 1'b1);
        chk({tag, "_awready"}, awready, 1'b1);
        chk({tag, "_wready"},  wready,  1'b1);
        chk({tag, "_rvalid"},  rvalid,  1'b0);
        chk({tag, "_bvalid"},  bvalid,  1'b0);
        chk({tag, "_rdata"},   rdata,   32'h0);
        chk({tag, "_rresp"},   rresp,   2'b00);
        chk({tag, "_bresp"},   bresp,   2'b00);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] d, d2;
        logic [1:0]  r, r2;
        int          lat, lat2;

        rstn = 1'b0;
        araddr = 0; arvalid = 0; rready = 0;
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        rstn = 1'b1;

        // reset then read: rvalid seen on the 3rd negedge after AR (RD_LAT=1)
        rd(BASE, 0, d, r, lat);
        chk("first_rd_lat", lat, 3);
        chk("first_rd_rresp", r, 2'b00);

        // strobed write
        wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat);
        chk("wr1_bresp", r, 2'b00);
        chk("wr1_lat", lat, WR_LAT + 1);
        wr(32'h8000_0010, 32'h1122_3344, 4'h5, 0, 0, r, lat);
        chk("wr2_bresp", r, 2'b00);
        rd(32'h8000_0010, 0, d, r, lat);
        chk("strobe_rdata", d, 32'hDE22_BE44);
        // byte-offset bits ignored
        rd(32'h8000_0013, 0, d, r, lat);
        chk("misalign_rdata", d, 32'hDE22_BE44);

        // W presented 3 cycles ahead of AW
        wr(BASE, 32'hCAFE_F00D, 4'hF, 0, 0, r, lat);
        wr(32'h8000_0020, 32'h0BAD_C0DE, 4'hF, 3, 0, r, lat);
        chk("wfirst_lat", lat, WR_LAT + 1);
        chk("wfirst_bresp", r, 2'b00);
        rd(32'h8000_0020, 0, d, r, lat);
        chk("wfirst_rdata", d, 32'h0BAD_C0DE);

        // out of range, both ends of the window
        rd(32'h8000_4000, 0, d, r, lat);
        chk("oor_rresp", r, 2'b11);
        chk("oor_rdata", d, 32'h0);
        rd(32'h7FFF_FFFC, 0, d, r, lat);
        chk("below_rresp", r, 2'b11);
        rd(32'h8000_3FFC, 0, d, r, lat);
        chk("last_word_rresp", r, 2'b00);
        wr(32'h8000_4000, 32'h1234_5678, 4'hF, 0, 0, r, lat);
        chk("oor_bresp", r, 2'b11);
        rd(BASE, 0, d, r, lat);
        chk("word0_unchanged", d, 32'hCAFE_F00D);

        // backpressure on both response channels
        rd(32'h8000_0010, 5, d, r, lat);
        chk("bp_rd_rdata", d, 32'hDE22_BE44);
        wr(32'h8000_0030, 32'hA5A5_5A5A, 4'hF, 0, 5, r, lat);
        chk("bp_wr_bresp", r, 2'b00);

        // concurrent read and write
        fork
            rd(32'h8000_0030, 0, d, r, lat);
            wr(32'h8000_0040, 32'h0102_0304, 4'hF, 0, 0, r2, lat2);
        join
        chk("conc_rdata", d, 32'hA5A5_5A5A);
        chk("conc_rd_lat", lat, RD_LAT + 2);
        chk("conc_wr_lat", lat2, WR_LAT + 1);
        rd(32'h8000_0040, 0, d, r, lat);
        chk("conc_wr_data", d, 32'h0102_0304);

        // reset while the write is waiting to commit
        @(negedge clk);
        awaddr = 32'h8000_0020; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("pre_rst_awready", awready, 1'b0);
        #2 rstn = 1'b0;
        #1 chk_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rd(32'h8000_0020, 0, d, r, lat);
        chk("midrst_kept", d, 32'h0BAD_C0DE);
        wr(32'h8000_0020, 32'h7777_8888, 4'hC, 0, 0, r, lat);
        chk("post_rst_bresp", r, 2'b00);
        rd(32'h8000_0020, 0, d, r, lat);
        chk("post_rst_rdata", d, 32'h7777_C0DE);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
